baud_tick_ctrl: RTL and testbench
=================================

BAUD_TICK_CTRL -- requirements
Module: baud_tick_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the oversample divisor.
REQ-002 SHALL have parameter OS_RATIO, default 16, oversample ticks per bit period; it SHALL be a power of two.
REQ-003 SHALL have parameter RESET_DIV, default 10, divisor value loaded at reset.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 input_clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  level; 1 = generate ticks, 0 = idle.
REQ-008 sync_clr  input  1  single-cycle pulse; re-aligns the bit phase (RX start-bit detect).
REQ-009 cfg_div  input  DIV_W  new divisor value.
REQ-010 cfg_valid  input  1  cfg_div offered.
REQ-011 cfg_ready  output  1  controller can accept a divisor.
REQ-012 os_tick  output  1  one-cycle oversample strobe.
REQ-013 bit_tick  output  1  one-cycle bit-period strobe.
REQ-014 phase  output  log2(OS_RATIO)  oversample index within the current bit.
REQ-015 div_active  output  DIV_W  divisor currently in use.

Function
REQ-016 States: IDLE, RUN; state SHALL be registered.
- IDLE to RUN on a rising edge with enable=1.
- RUN to IDLE on a rising edge with enable=0.
REQ-017 In IDLE:
- os counter and phase SHALL be held at 0.
- os_tick and bit_tick SHALL be 0.
REQ-018 In RUN, the os counter SHALL count 0..div_active-1 and wrap to 0.
REQ-019 os_tick SHALL be 1 in exactly the cycles where the os counter equals div_active-1, so the first os_tick occurs in the div_active-th RUN cycle.
REQ-020 phase SHALL increment modulo OS_RATIO on every os_tick.
REQ-021 bit_tick SHALL be 1 only when os_tick=1 and phase=OS_RATIO-1; this gives one bit_tick per OS_RATIO*div_active cycles.
REQ-022 A divisor of 0 SHALL be treated as 1, meaning os_tick is asserted every RUN cycle.
REQ-023 Config handshake: the divisor is transferred on a cycle with cfg_valid=1 and cfg_ready=1, and SHALL be captured into a pending register.
REQ-024 cfg_ready SHALL be 1 when no divisor is pending and 0 otherwise.
REQ-025 In RUN, a pending divisor SHALL become div_active on the cycle after the next bit_tick, and cfg_ready SHALL rise in that same cycle.
- No partial bit period SHALL use a mixed divisor.
REQ-026 In IDLE, a pending divisor SHALL become div_active on the cycle after capture.
REQ-027 sync_clr=1 in RUN SHALL clear the os counter and phase to 0 on that edge.
- os_tick and bit_tick SHALL be suppressed in that cycle.
- A pending divisor SHALL be applied at the same edge.
REQ-028 sync_clr in IDLE SHALL have no effect.
REQ-029 If enable falls in the same cycle as sync_clr or a bit_tick, the IDLE transition SHALL take priority; a pending divisor SHALL then apply per REQ-026.
REQ-030 cfg_valid while cfg_ready=0 SHALL be ignored; the source holds cfg_valid until cfg_ready=1.
REQ-031 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-032 Reset SHALL force the following values immediately, independent of input_clk:
- state=IDLE
- os counter=0
- phase=0
- os_tick=0, bit_tick=0
- no divisor pending, cfg_ready=1
- div_active=RESET_DIV
REQ-033 Reset asserted mid-RUN SHALL abort the bit period and discard any pending divisor.
REQ-034 After reset deassertion, the first tick SHALL follow REQ-019 timing from the first RUN cycle.

Structure
REQ-035 A shared package baud_pkg SHALL hold:
- DIV_W default
- OS_RATIO default
- the state enum (IDLE, RUN)
REQ-036 A sub-module baud_counter SHALL implement the clearable, wrapping os counter and its terminal-count strobe; baud_tick_ctrl instantiates it once.

Verification
REQ-037 Bench SHALL drive a free-running input_clk and apply each scenario below.
- Reset, then div=4 via handshake, enable=1: os_tick every 4 cycles; first os_tick in RUN cycle 4; bit_tick every 64 cycles; phase sequence 0..15.
- Running at div=4, offer div=2 at phase 5: cfg_ready=0 until the cycle after the next bit_tick; that bit period lasts 64 cycles, the following one 32.
- div=0, enable=1: os_tick every cycle; bit_tick every 16 cycles; div_active=0.
- sync_clr at phase 9, counter 2: next cycle phase=0, counter=0; next os_tick 4 cycles after sync_clr; no tick in the sync_clr cycle.
- Reset asserted mid-RUN with a divisor pending: outputs go to REQ-032 values without a clock edge; div_active=10; cfg_ready=1.
- enable dropped in the bit_tick cycle with a divisor pending: next cycle IDLE with ticks 0; divisor applied the cycle after.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared defaults and FSM encoding for the baud tick controller and its counter.
package baud_pkg;

  localparam int DEF_DIV_W     = 16;
  localparam int DEF_OS_RATIO  = 16;
  localparam int DEF_RESET_DIV = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/baud_counter.sv
// Clearable, wrapping oversample counter; o_tc marks the last count of each
// oversample period for the divisor currently applied.
module baud_counter
  import baud_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic [DIV_W-1:0] o_count,
  output logic             o_tc
);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] w_last;

  // A zero divisor behaves as one: the counter sits at 0 and strobes every cycle.
  assign w_last  = (i_div == '0) ? '0 : (i_div - DIV_W'(1));
  assign o_tc    = (r_count == w_last);
  assign o_count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tc ? '0 : (r_count + DIV_W'(1));
    end
  end

endmodule

// File: rtl/baud_tick_ctrl.sv
// Baud tick controller: oversample and bit-period strobes from a runtime divisor,
// with a bit-aligned divisor handover and a phase re-align input for RX start bits.
module baud_tick_ctrl
  import baud_pkg::*;
#(
  parameter int  DIV_W     = DEF_DIV_W,
  parameter int  OS_RATIO  = DEF_OS_RATIO,
  parameter int  RESET_DIV = DEF_RESET_DIV,
  localparam int PH_W      = (OS_RATIO > 1) ? $clog2(OS_RATIO) : 1
) (
  input  logic             input_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_clr,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             os_tick,
  output logic             bit_tick,
  output logic [PH_W-1:0]  phase,
  output logic [DIV_W-1:0] div_active,
  output logic             o_dbg_state,
  output logic [DIV_W-1:0] o_dbg_count
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_pending;
  logic [DIV_W-1:0] r_pend_div;
  logic [DIV_W-1:0] r_div_active;
  logic [PH_W-1:0]  r_phase;

  logic             w_run;
  logic             w_hold;
  logic             w_apply;
  logic             w_tc;
  logic             w_os_tick;
  logic             w_bit_tick;
  logic             w_cfg_fire;
  logic [DIV_W-1:0] w_count;

  assign w_run      = (r_state == RUN);
  assign w_os_tick  = w_run && w_tc;
  assign w_bit_tick = w_os_tick && (r_phase == PH_W'(OS_RATIO - 1));

  // Config handshake: a divisor transfers on any edge where cfg_valid and cfg_ready
  // are both high; cfg_ready is low exactly while a captured divisor awaits handover.
  assign w_cfg_fire = cfg_valid && !r_pending;

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Dropping enable wins over sync_clr and bit_tick, so a pending divisor then
  // waits for the first IDLE edge instead of the bit boundary.
  always_comb begin
    w_state_next = r_state;
    w_hold       = 1'b1;
    w_apply      = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next = RUN;
        end
        w_apply = r_pending;
      end
      RUN: begin
        if (!enable) begin
          w_state_next = IDLE;
        end else begin
          w_hold  = sync_clr;
          w_apply = r_pending && (sync_clr || w_bit_tick);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  baud_counter #(
    .DIV_W (DIV_W)
  ) u_counter (
    .i_clk   (input_clk),
    .i_rst   (reset),
    .i_clr   (w_hold),
    .i_en    (w_run),
    .i_div   (r_div_active),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
    end else if (w_hold) begin
      r_phase <= '0;
    end else if (w_os_tick) begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      r_pending  <= 1'b0;
      r_pend_div <= '0;
    end else if (w_cfg_fire) begin
      r_pending  <= 1'b1;
      r_pend_div <= cfg_div;
    end else if (w_apply) begin
      r_pending  <= 1'b0;
    end
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      r_div_active <= DIV_W'(RESET_DIV);
    end else if (w_apply) begin
      r_div_active <= r_pend_div;
    end
  end

  assign cfg_ready   = !r_pending;
  assign os_tick     = w_os_tick;
  assign bit_tick    = w_bit_tick;
  assign phase       = r_phase;
  assign div_active  = r_div_active;
  assign o_dbg_state = w_run;
  assign o_dbg_count = w_count;

endmodule

// File: tb/tb_baud_tick_ctrl.sv
// Bench for baud_tick_ctrl: directed scenarios plus a randomized run scored
// against a cycle-count model of the tick timing.
module tb_baud_tick_ctrl;

  localparam int DIV_W     = 16;
  localparam int OS_RATIO  = 16;
  localparam int RESET_DIV = 10;
  localparam int PH_W      = 4;
  localparam int EXP_W     = 4 + PH_W + 2 * DIV_W;

  logic             input_clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             sync_clr;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             os_tick;
  logic             bit_tick;
  logic [PH_W-1:0]  phase;
  logic [DIV_W-1:0] div_active;
  logic             dbg_state;
  logic [DIV_W-1:0] dbg_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_bt = -1;

  // Reference model: position m_k within the current bit period, in clock cycles.
  bit m_run;
  int m_k;
  int m_div;
  bit m_pend;
  int m_pdiv;

  logic [EXP_W-1:0] exp_q[$];

  baud_tick_ctrl #(
    .DIV_W     (DIV_W),
    .OS_RATIO  (OS_RATIO),
    .RESET_DIV (RESET_DIV)
  ) dut (
    .input_clk   (input_clk),
    .reset       (reset),
    .enable      (enable),
    .sync_clr    (sync_clr),
    .cfg_div     (cfg_div),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .os_tick     (os_tick),
    .bit_tick    (bit_tick),
    .phase       (phase),
    .div_active  (div_active),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  always #5 input_clk = ~input_clk;

  function automatic int model_eff();
    return (m_div == 0) ? 1 : m_div;
  endfunction

  function automatic void model_reset();
    m_run  = 1'b0;
    m_k    = 0;
    m_div  = RESET_DIV;
    m_pend = 1'b0;
    m_pdiv = 0;
  endfunction

  function automatic void model_step(bit en, bit sc, bit cv, int cd);
    int  per;
    bit  bt;
    bit  cap;
    bit  apply;
    per   = model_eff() * OS_RATIO;
    bt    = m_run && (m_k == per - 1);
    cap   = cv && !m_pend;
    apply = m_pend && (!m_run || (en && (sc || bt)));
    if (m_run && en && !sc) m_k = (m_k + 1) % per;
    else m_k = 0;
    if (apply) begin
      m_div  = m_pdiv;
      m_pend = 1'b0;
    end
    if (cap) begin
      m_pend = 1'b1;
      m_pdiv = cd;
    end
    m_run = en;
  endfunction

  function automatic logic [EXP_W-1:0] model_vec();
    int eff;
    eff = model_eff();
    return {m_run, !m_pend, m_run && (((m_k + 1) % eff) == 0),
            m_run && (m_k == eff * OS_RATIO - 1),
            PH_W'(m_k / eff), DIV_W'(m_k % eff), DIV_W'(m_div)};
  endfunction

  task automatic cycle();
    @(posedge input_clk);
    model_step(enable, sync_clr, cfg_valid, int'(cfg_div));
    exp_q.push_back(model_vec());
    @(negedge input_clk);
    cyc++;
    if (bit_tick === 1'b1) last_bt = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    model_reset();
    repeat (2) @(negedge input_clk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %0b exp 1", cfg_ready); end
    checks++; if (div_active !== DIV_W'(RESET_DIV)) begin errors++; $display("FAIL reset_div got %0d exp %0d", div_active, RESET_DIV); end
    checks++; if ({os_tick, bit_tick, dbg_state} !== 3'b000) begin errors++; $display("FAIL reset_ticks got %b exp 000", {os_tick, bit_tick, dbg_state}); end
    checks++; if (phase !== '0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    reset = 1'b0;
  endtask

  task automatic test_div4();
    int first_os;
    int n_os;
    int n_bt;
    int bt_at[2];
    cfg_div = 16'd4; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL div4_pending got %0b exp 0", cfg_ready); end
    cycle();
    checks++; if (div_active !== 16'd4) begin errors++; $display("FAIL div4_apply got %0d exp 4", div_active); end
    enable = 1'b1;
    first_os = -1; n_os = 0; n_bt = 0;
    for (int n = 1; n <= 130; n++) begin
      cycle();
      if (os_tick === 1'b1) begin
        if (first_os < 0) first_os = n;
        checks++;
        if (phase !== PH_W'(n_os % OS_RATIO)) begin
          errors++; $display("FAIL div4_phase cycle %0d got %0d exp %0d", n, phase, n_os % OS_RATIO);
        end
        n_os++;
      end
      if (bit_tick === 1'b1) begin
        if (n_bt < 2) bt_at[n_bt] = n;
        n_bt++;
      end
    end
    checks++; if (first_os !== 4) begin errors++; $display("FAIL div4_first_os got %0d exp 4", first_os); end
    checks++; if (n_os !== 32) begin errors++; $display("FAIL div4_os_count got %0d exp 32", n_os); end
    checks++; if (n_bt !== 2) begin errors++; $display("FAIL div4_bt_count got %0d exp 2", n_bt); end
    else begin
      checks++; if (bt_at[0] !== 64 || bt_at[1] !== 128) begin errors++; $display("FAIL div4_bt_cycles got %0d,%0d exp 64,128", bt_at[0], bt_at[1]); end
    end
  endtask

  task automatic test_div_change();
    int t0;
    int t1;
    int t2;
    int ready_bad;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cycle();
      if (m_k == 5 * model_eff()) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL chg_wait_phase5 got timeout exp phase 5"); end
    t0 = last_bt;
    cfg_div = 16'd2; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    seen = 1'b0; ready_bad = 0; t1 = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (cfg_ready !== 1'b0) ready_bad++;
      if (bit_tick === 1'b1) begin seen = 1'b1; t1 = cyc; end
      else cycle();
    end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL chg_ready_low got %0d high cycles exp 0", ready_bad); end
    checks++; if (t1 - t0 !== 64) begin errors++; $display("FAIL chg_period_old got %0d exp 64", t1 - t0); end
    cycle();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL chg_ready_rise got %0b exp 1", cfg_ready); end
    checks++; if (div_active !== 16'd2) begin errors++; $display("FAIL chg_div got %0d exp 2", div_active); end
    t2 = -1;
    for (int i = 0; i < 100 && t2 < 0; i++) begin
      cycle();
      if (bit_tick === 1'b1) t2 = cyc;
    end
    checks++; if (t2 - t1 !== 32) begin errors++; $display("FAIL chg_period_new got %0d exp 32", t2 - t1); end
  endtask

  task automatic test_div0();
    int os_bad;
    int n_bt;
    int first_bt;
    int last;
    enable = 1'b0; cfg_div = '0; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    checks++; if ({dbg_state, os_tick} !== 2'b00) begin errors++; $display("FAIL div0_idle got %b exp 00", {dbg_state, os_tick}); end
    cycle();
    checks++; if (div_active !== '0) begin errors++; $display("FAIL div0_apply got %0d exp 0", div_active); end
    enable = 1'b1;
    os_bad = 0; n_bt = 0; first_bt = -1; last = -1;
    for (int n = 1; n <= 48; n++) begin
      cycle();
      if (os_tick !== 1'b1) os_bad++;
      if (bit_tick === 1'b1) begin
        if (first_bt < 0) first_bt = n;
        last = n;
        n_bt++;
      end
    end
    checks++; if (os_bad !== 0) begin errors++; $display("FAIL div0_os_every got %0d gaps exp 0", os_bad); end
    checks++; if (n_bt !== 3 || first_bt !== 16 || last !== 48) begin
      errors++; $display("FAIL div0_bt got n=%0d first=%0d last=%0d exp n=3 first=16 last=48", n_bt, first_bt, last);
    end
  endtask

  task automatic test_sync_clr();
    bit seen;
    int first_os;
    enable = 1'b0; cfg_div = 16'd4; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    cycle();
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cycle();
      if (m_run && m_k == 9 * 4 + 2) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL sync_wait got timeout exp phase 9 count 2"); end
    checks++; if (phase !== 4'd9 || dbg_count !== 16'd2) begin errors++; $display("FAIL sync_pre got phase %0d count %0d exp 9 2", phase, dbg_count); end
    checks++; if ({os_tick, bit_tick} !== 2'b00) begin errors++; $display("FAIL sync_no_tick got %b exp 00", {os_tick, bit_tick}); end
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    checks++; if (phase !== '0 || dbg_count !== '0) begin errors++; $display("FAIL sync_cleared got phase %0d count %0d exp 0 0", phase, dbg_count); end
    first_os = (os_tick === 1'b1) ? 1 : -1;
    for (int j = 2; j <= 10 && first_os < 0; j++) begin
      cycle();
      if (os_tick === 1'b1) first_os = j;
    end
    checks++; if (first_os !== 4) begin errors++; $display("FAIL sync_next_os got %0d exp 4", first_os); end
  endtask

  task automatic test_reset_mid_run();
    int first_os;
    cfg_div = 16'd7; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    repeat (5) cycle();
    checks++; if (cfg_ready !== 1'b0 || dbg_state !== 1'b1) begin errors++; $display("FAIL rst_pre got ready %0b run %0b exp 0 1", cfg_ready, dbg_state); end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if ({dbg_state, os_tick, bit_tick} !== 3'b000 || phase !== '0 || dbg_count !== '0) begin
      errors++; $display("FAIL rst_async got st/os/bt %b phase %0d count %0d exp 000 0 0", {dbg_state, os_tick, bit_tick}, phase, dbg_count);
    end
    checks++; if (cfg_ready !== 1'b1 || div_active !== DIV_W'(RESET_DIV)) begin
      errors++; $display("FAIL rst_cfg got ready %0b div %0d exp 1 %0d", cfg_ready, div_active, RESET_DIV);
    end
    #1;
    reset = 1'b0;
    first_os = -1;
    for (int n = 1; n <= 12 && first_os < 0; n++) begin
      cycle();
      if (os_tick === 1'b1) first_os = n;
    end
    checks++; if (first_os !== RESET_DIV) begin errors++; $display("FAIL rst_first_os got %0d exp %0d", first_os, RESET_DIV); end
  endtask

  task automatic test_enable_drop();
    bit seen;
    cfg_div = 16'd3; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      cycle();
      if (m_run && m_k == model_eff() * OS_RATIO - 1) seen = 1'b1;
    end
    checks++; if (!seen || bit_tick !== 1'b1) begin errors++; $display("FAIL drop_bt got %0b exp 1", bit_tick); end
    enable = 1'b0;
    cycle();
    checks++; if ({dbg_state, os_tick, bit_tick} !== 3'b000) begin errors++; $display("FAIL drop_idle got %b exp 000", {dbg_state, os_tick, bit_tick}); end
    checks++; if (div_active !== DIV_W'(RESET_DIV) || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL drop_hold got div %0d ready %0b exp %0d 0", div_active, cfg_ready, RESET_DIV);
    end
    cycle();
    checks++; if (div_active !== 16'd3 || cfg_ready !== 1'b1) begin errors++; $display("FAIL drop_apply got div %0d ready %0b exp 3 1", div_active, cfg_ready); end
  endtask

  task automatic test_random();
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] got_v;
    bit xfer;
    exp_q.delete();
    enable = 1'b1; sync_clr = 1'b0; cfg_valid = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      xfer = cfg_valid && cfg_ready;
      cycle();
      sync_clr = 1'b0;
      if (xfer) cfg_valid = 1'b0;
      got_v = {dbg_state, cfg_ready, os_tick, bit_tick, phase, dbg_count, div_active};
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL random_queue cycle %0d got empty exp entry", i);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          errors++; $display("FAIL random cycle %0d got %h exp %h", i, got_v, exp_v);
        end
      end
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) sync_clr = 1'b1;
      if (!cfg_valid && $urandom_range(0, 19) == 0) begin
        cfg_valid = 1'b1;
        cfg_div = DIV_W'($urandom_range(0, 5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div_change();
    test_div0();
    test_sync_clr();
    test_reset_mid_run();
    test_enable_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
